hazard_ctrl: RTL and testbench

Hazard and next-PC controller for the 5-stage pipelined CPU. It is the producer side of the PC register: it generates the next-PC value, the PC hold request and the branch-redirect flag, plus the IF/ID and ID/EX stall and flush controls. It detects load-use and branch-operand hazards, and tracks a multi-cycle mult/div unit (MDU) with a busy countdown. It also keeps a stall-cycle performance counter.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/hazard_ctrl_if.sv | 53 +++++
 rtl/hazard_ctrl_mdu_busy_tracker.sv | 65 ++++++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the hazard/next-PC controller and the MDU
// datapath: MDU tracker state encoding, architectural constants, default
// mult/div latencies and a small register-dependency helper.
package cpu_pkg;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Width of the MDU busy countdown; latencies must fit in it (1..63).
  localparam int MD_CNT_W = 6;

  // Default latencies, shared with the MDU datapath so both agree.
  localparam int MULT_LAT_DEFAULT = 4;
  localparam int DIV_LAT_DEFAULT  = 32;

  // True when a source that is actually read names the given destination.
  // Register 0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_dep(input logic       uses_src,
                                   input logic [4:0] src,
                                   input logic [4:0] dst);
    return uses_src && (src == dst) && (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals exchanged with the hazard/next-PC
// controller.
//   master : the pipeline (drives ID/EX/MEM status and the current PC,
//            receives next PC and stall/flush controls)
//   slave  : hazard_ctrl
interface hazard_ctrl_if;

  logic [31:0] pc_now;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_is_branch;
  logic        id_branch_taken;
  logic [31:0] id_branch_target;
  logic        id_is_mult;
  logic        id_is_div;
  logic        id_reads_hilo;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        mem_mem_read;
  logic [4:0]  mem_rd;

  logic [31:0] pc_in;
  logic        pc_hazard;
  logic        branch_yn;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mdu_busy;
  logic [31:0] stall_cycles;

  modport master (
    output pc_now, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_is_branch, id_branch_taken, id_branch_target,
           id_is_mult, id_is_div, id_reads_hilo,
           ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd,
    input  pc_in, pc_hazard, branch_yn, if_id_stall, if_id_flush,
           id_ex_flush, mdu_busy, stall_cycles
  );

  modport slave (
    input  pc_now, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_is_branch, id_branch_taken, id_branch_target,
           id_is_mult, id_is_div, id_reads_hilo,
           ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd,
    output pc_in, pc_hazard, branch_yn, if_id_stall, if_id_flush,
           id_ex_flush, mdu_busy, stall_cycles
  );

endinterface

// File: rtl/hazard_ctrl_mdu_busy_tracker.sv
// Busy countdown for the multi-cycle mult/div unit.
//   clk, reset  : clock, synchronous active-high reset
//   issue_mult  : a mult leaves ID this cycle
//   issue_div   : a div leaves ID this cycle (wins over issue_mult)
//   md_cnt      : remaining busy cycles (0 = idle)
//   mdu_busy    : registered md_cnt != 0
module mdu_busy_tracker
  import cpu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_mult,
  input  logic                issue_div,
  output logic [MD_CNT_W-1:0] md_cnt,
  output logic                mdu_busy
);

  localparam logic [MD_CNT_W-1:0] MULT_CNT = MD_CNT_W'(MULT_LAT);
  localparam logic [MD_CNT_W-1:0] DIV_CNT  = MD_CNT_W'(DIV_LAT);

  mdu_state_t state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MDU_IDLE;
      md_cnt   <= '0;
      mdu_busy <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (issue_div) begin
            state    <= MDU_BUSY;
            md_cnt   <= DIV_CNT;
            mdu_busy <= 1'b1;
          end else if (issue_mult) begin
            state    <= MDU_BUSY;
            md_cnt   <= MULT_CNT;
            mdu_busy <= 1'b1;
          end
        end
        MDU_BUSY: begin
          // No issue can arrive here: an MDU op in ID stalls while busy.
          if (md_cnt <= MD_CNT_W'(1)) begin
            state    <= MDU_IDLE;
            md_cnt   <= '0;
            mdu_busy <= 1'b0;
          end else begin
            md_cnt <= md_cnt - MD_CNT_W'(1);
          end
        end
        default: begin
          state    <= MDU_IDLE;
          md_cnt   <= '0;
          mdu_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and next-PC controller for the 5-stage pipeline.
//   clk, reset : clock, synchronous active-high reset
//   hif        : slave side of hazard_ctrl_if
//                inputs  - current PC, ID source/branch/MDU info,
//                          EX and MEM destination info
//                outputs - next PC, PC hold, redirect flag, IF/ID stall and
//                          flush, ID/EX flush, MDU busy, stall-cycle counter
// Hazard decisions are combinational in the same cycle; only the MDU
// countdown and the stall counter are registered.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MULT_LAT         = MULT_LAT_DEFAULT,
  parameter int DIV_LAT          = DIV_LAT_DEFAULT,
  parameter bit FLUSH_DELAY_SLOT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hif
);

  logic                load_use;
  logic                br_dep;
  logic                mdu_conflict;
  logic                stall;
  logic                issue_mult;
  logic                issue_div;
  logic [MD_CNT_W-1:0] md_cnt;
  logic                mdu_busy;
  logic [31:0]         stall_cnt;

  logic [31:0] pc_in;
  logic        pc_hazard;
  logic        branch_yn;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_flush;

  // Any read source in ID that names the given destination.
  function automatic logic src_dep(input logic [4:0] dst);
    return reg_dep(hif.id_uses_rs, hif.id_rs, dst) ||
           reg_dep(hif.id_uses_rt, hif.id_rt, dst);
  endfunction

  always_comb begin
    load_use     = hif.id_valid && hif.ex_mem_read && src_dep(hif.ex_rd);
    // A branch resolved in ID needs its operands now: an ALU result still
    // in EX or a load still in MEM cannot be forwarded in time.
    br_dep       = hif.id_valid && hif.id_is_branch &&
                   ((hif.ex_reg_write  && src_dep(hif.ex_rd)) ||
                    (hif.mem_mem_read  && src_dep(hif.mem_rd)));
    mdu_conflict = hif.id_valid && (md_cnt != '0) &&
                   (hif.id_is_mult || hif.id_is_div || hif.id_reads_hilo);
    stall        = load_use || br_dep || mdu_conflict;
    issue_div    = hif.id_valid && !stall && hif.id_is_div;
    issue_mult   = hif.id_valid && !stall && hif.id_is_mult && !hif.id_is_div;
  end

  // NOTE: every output gets a default before the priority chain, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pc_in       = hif.pc_now + PC_STEP;
    pc_hazard   = 1'b0;
    branch_yn   = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (reset) begin
      pc_in = '0;
    end else if (stall) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX; a pending branch is
      // re-evaluated once its operands are ready.
      pc_hazard   = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hif.id_is_branch && hif.id_branch_taken) begin
      branch_yn   = 1'b1;
      pc_in       = hif.id_branch_target;
      if_id_flush = FLUSH_DELAY_SLOT;
    end
  end

  mdu_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_mdu (
    .clk        (clk),
    .reset      (reset),
    .issue_mult (issue_mult),
    .issue_div  (issue_div),
    .md_cnt     (md_cnt),
    .mdu_busy   (mdu_busy)
  );

  // Saturating stall-cycle performance counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign hif.pc_in        = pc_in;
  assign hif.pc_hazard    = pc_hazard;
  assign hif.branch_yn    = branch_yn;
  assign hif.if_id_stall  = if_id_stall;
  assign hif.if_id_flush  = if_id_flush;
  assign hif.id_ex_flush  = id_ex_flush;
  assign hif.mdu_busy     = mdu_busy;
  assign hif.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances share stimulus and differ
// only in FLUSH_DELAY_SLOT. Inputs change on the falling edge; outputs are
// sampled 1 ns later, well away from the rising edge.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] pc_now;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt;
  logic        id_is_branch, id_branch_taken;
  logic [31:0] id_branch_target;
  logic        id_is_mult, id_is_div, id_reads_hilo;
  logic        ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        mem_mem_read;
  logic [4:0]  mem_rd;

  int n_checks;
  int n_errors;

  hazard_ctrl_if if0 ();
  hazard_ctrl_if if1 ();

  assign if0.pc_now           = pc_now;
  assign if0.id_valid         = id_valid;
  assign if0.id_rs            = id_rs;
  assign if0.id_rt            = id_rt;
  assign if0.id_uses_rs       = id_uses_rs;
  assign if0.id_uses_rt       = id_uses_rt;
  assign if0.id_is_branch     = id_is_branch;
  assign if0.id_branch_taken  = id_branch_taken;
  assign if0.id_branch_target = id_branch_target;
  assign if0.id_is_mult       = id_is_mult;
  assign if0.id_is_div        = id_is_div;
  assign if0.id_reads_hilo    = id_reads_hilo;
  assign if0.ex_reg_write     = ex_reg_write;
  assign if0.ex_mem_read      = ex_mem_read;
  assign if0.ex_rd            = ex_rd;
  assign if0.mem_mem_read     = mem_mem_read;
  assign if0.mem_rd           = mem_rd;

  assign if1.pc_now           = pc_now;
  assign if1.id_valid         = id_valid;
  assign if1.id_rs            = id_rs;
  assign if1.id_rt            = id_rt;
  assign if1.id_uses_rs       = id_uses_rs;
  assign if1.id_uses_rt       = id_uses_rt;
  assign if1.id_is_branch     = id_is_branch;
  assign if1.id_branch_taken  = id_branch_taken;
  assign if1.id_branch_target = id_branch_target;
  assign if1.id_is_mult       = id_is_mult;
  assign if1.id_is_div        = id_is_div;
  assign if1.id_reads_hilo    = id_reads_hilo;
  assign if1.ex_reg_write     = ex_reg_write;
  assign if1.ex_mem_read      = ex_mem_read;
  assign if1.ex_rd            = ex_rd;
  assign if1.mem_mem_read     = mem_mem_read;
  assign if1.mem_rd           = mem_rd;

  hazard_ctrl #(
    .MULT_LAT         (4),
    .DIV_LAT          (32),
    .FLUSH_DELAY_SLOT (1'b0)
  ) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .hif   (if0.slave)
  );

  hazard_ctrl #(
    .MULT_LAT         (4),
    .DIV_LAT          (32),
    .FLUSH_DELAY_SLOT (1'b1)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .hif   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_valid         = 1'b0;
    id_rs            = 5'd0;
    id_rt            = 5'd0;
    id_uses_rs       = 1'b0;
    id_uses_rt       = 1'b0;
    id_is_branch     = 1'b0;
    id_branch_taken  = 1'b0;
    id_branch_target = 32'd0;
    id_is_mult       = 1'b0;
    id_is_div        = 1'b0;
    id_reads_hilo    = 1'b0;
    ex_reg_write     = 1'b0;
    ex_mem_read      = 1'b0;
    ex_rd            = 5'd0;
    mem_mem_read     = 1'b0;
    mem_rd           = 5'd0;
  endtask

  // Advance one full cycle; returns on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    pc_now   = 32'h40;
    idle_inputs();

    // Reset forces controls low and pc_in to zero even with a load-use.
    @(negedge clk);
    id_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8;
    id_rs = 5'd8; id_uses_rs = 1'b1;
    #1;
    check("rst_pc_in",     if0.pc_in,       32'h0);
    check("rst_pc_hazard", {31'd0, if0.pc_hazard},   32'd0);
    check("rst_id_ex_fl",  {31'd0, if0.id_ex_flush}, 32'd0);
    tick();
    idle_inputs();
    tick();
    check("rst_stall_cnt", if0.stall_cycles, 32'd0);
    check("rst_mdu_busy",  {31'd0, if0.mdu_busy}, 32'd0);
    reset = 1'b0;
    #1;
    check("idle_pc_in",    if0.pc_in, 32'h44);

    // Load-use on rs.
    id_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8;
    id_rs = 5'd8; id_uses_rs = 1'b1;
    #1;
    check("lu_pc_hazard",  {31'd0, if0.pc_hazard},   32'd1);
    check("lu_if_id_stl",  {31'd0, if0.if_id_stall}, 32'd1);
    check("lu_id_ex_fl",   {31'd0, if0.id_ex_flush}, 32'd1);
    check("lu_branch_yn",  {31'd0, if0.branch_yn},   32'd0);
    check("lu_pc_in",      if0.pc_in, 32'h44);
    tick();
    check("lu_stall_cnt",  if0.stall_cycles, 32'd1);

    // Register 0 never matches.
    ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    check("lu_r0_hazard",  {31'd0, if0.pc_hazard}, 32'd0);
    // rt path, then rt not actually read.
    ex_rd = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1;
    #1;
    check("lu_rt_hazard",  {31'd0, if0.pc_hazard}, 32'd1);
    id_uses_rt = 1'b0;
    #1;
    check("lu_rt_unused",  {31'd0, if0.pc_hazard}, 32'd0);
    // Invalid ID slot never stalls.
    id_uses_rt = 1'b1; id_valid = 1'b0;
    #1;
    check("lu_invalid",    {31'd0, if0.pc_hazard}, 32'd0);
    tick();
    check("lu_cnt_hold",   if0.stall_cycles, 32'd1);

    // Taken branch without hazard, both delay-slot modes; then not taken.
    idle_inputs();
    pc_now = 32'h100; id_valid = 1'b1; id_is_branch = 1'b1;
    id_branch_taken = 1'b1; id_branch_target = 32'h200;
    #1;
    check("br_branch_yn",  {31'd0, if0.branch_yn},   32'd1);
    check("br_pc_in",      if0.pc_in, 32'h200);
    check("br_pc_hazard",  {31'd0, if0.pc_hazard},   32'd0);
    check("br_flush_ds0",  {31'd0, if0.if_id_flush}, 32'd0);
    check("br_flush_ds1",  {31'd0, if1.if_id_flush}, 32'd1);
    check("br_pc_in_ds1",  if1.pc_in, 32'h200);
    id_branch_taken = 1'b0;
    #1;
    check("bnt_branch_yn", {31'd0, if0.branch_yn}, 32'd0);
    check("bnt_pc_in",     if0.pc_in, 32'h104);

    // Branch depends on an ALU result in EX.
    id_branch_taken = 1'b1; id_rs = 5'd9; id_uses_rs = 1'b1;
    ex_reg_write = 1'b1; ex_rd = 5'd9;
    #1;
    check("brd_pc_hazard", {31'd0, if0.pc_hazard},   32'd1);
    check("brd_branch_yn", {31'd0, if0.branch_yn},   32'd0);
    check("brd_pc_in",     if0.pc_in, 32'h104);
    check("brd_flush_ds1", {31'd0, if1.if_id_flush}, 32'd0);
    tick();
    ex_reg_write = 1'b0;
    #1;
    check("brd2_branch_yn", {31'd0, if0.branch_yn}, 32'd1);
    check("brd2_pc_in",     if0.pc_in, 32'h200);
    check("brd_stall_cnt",  if0.stall_cycles, 32'd2);
    // Branch depends on a load in MEM.
    mem_mem_read = 1'b1; mem_rd = 5'd9;
    #1;
    check("brm_pc_hazard", {31'd0, if0.pc_hazard}, 32'd1);
    mem_mem_read = 1'b0;

    // Div issue at cycle t, mfhi waits exactly 32 cycles.
    idle_inputs();
    pc_now = 32'h300; id_valid = 1'b1; id_is_div = 1'b1;
    #1;
    check("div_issue_haz", {31'd0, if0.pc_hazard}, 32'd0);
    tick();
    id_is_div = 1'b0; id_reads_hilo = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      #1;
      check($sformatf("div_stall_%0d", k), {31'd0, if0.pc_hazard}, 32'd1);
      check($sformatf("div_busy_%0d", k),  {31'd0, if0.mdu_busy},  32'd1);
      tick();
    end
    #1;
    check("div_done_haz",  {31'd0, if0.pc_hazard}, 32'd0);
    check("div_done_busy", {31'd0, if0.mdu_busy},  32'd0);
    check("div_stall_cnt", if0.stall_cycles, 32'd34);

    // Mult: 4 busy cycles.
    id_reads_hilo = 1'b0; id_is_mult = 1'b1;
    tick();
    id_is_mult = 1'b0; id_reads_hilo = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("mul_stall_%0d", k), {31'd0, if0.pc_hazard}, 32'd1);
      tick();
    end
    #1;
    check("mul_done_haz",  {31'd0, if0.pc_hazard}, 32'd0);

    // Both mult and div set: div latency wins; reset while md_cnt == 10.
    id_reads_hilo = 1'b0; id_is_mult = 1'b1; id_is_div = 1'b1;
    tick();
    id_is_mult = 1'b0; id_is_div = 1'b0; id_reads_hilo = 1'b1;
    for (int k = 0; k < 22; k++) tick();
    #1;
    check("both_div_wins", {31'd0, if0.pc_hazard}, 32'd1);
    check("md_cnt_10",     {26'd0, u_dut0.md_cnt}, 32'd10);
    reset = 1'b1;
    tick();
    #1;
    check("rstb_md_cnt",   {26'd0, u_dut0.md_cnt}, 32'd0);
    check("rstb_busy",     {31'd0, if0.mdu_busy},  32'd0);
    check("rstb_stl_cnt",  if0.stall_cycles, 32'd0);
    reset = 1'b0;
    #1;
    check("rstb_mfhi_go",  {31'd0, if0.pc_hazard}, 32'd0);

    // PC wrap.
    idle_inputs();
    pc_now = 32'hFFFF_FFFC;
    #1;
    check("wrap_pc_in",    if0.pc_in, 32'h0000_0000);

    // Saturation: preload the counter at its maximum, then keep stalling.
    force u_dut0.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release u_dut0.stall_cnt;
    id_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs = 5'd5; id_uses_rs = 1'b1;
    tick();
    check("sat_cnt_1",     if0.stall_cycles, 32'hFFFF_FFFF);
    tick();
    check("sat_cnt_2",     if0.stall_cycles, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
